// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: mux select codes and TX sequencer states.
package uart_pkg;

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
    localparam logic [1:0] SEL_PARITY = 2'b10;
    localparam logic [1:0] SEL_STOP   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // IDLE shares the stop code so the line rests high between frames.
    function automatic logic [1:0] sel_of(input tx_state_t s);
        case (s)
            ST_START:  return SEL_START;
            ST_DATA:   return SEL_DATA;
            ST_PARITY: return SEL_PARITY;
            default:   return SEL_STOP;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud timer: counts 0..CLKS_PER_BIT-1 while enabled; tick marks the last cycle of each bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames a latched word as start/data/parity/stop and drives tx_mux.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           selection,
    output logic                 start_bit,
    output logic                 data_bit,
    output logic                 parity_bit,
    output logic                 stop_bit
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_tx_ctrl: CLKS_PER_BIT must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
            $error("uart_tx_ctrl: DATA_BITS must be 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_sb
            $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    tx_state_t            state, state_next;
    logic                 tick;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [1:0]           sel_next;
    logic                 busy_next, done_next;
    logic                 accept;
    logic                 parity_calc;

    assign accept      = (state == ST_IDLE) && tx_start;
    assign parity_calc = (^tx_data) ^ (PARITY_ODD != 0);
    assign start_bit   = 1'b0;
    assign stop_bit    = 1'b1;
    assign data_bit    = shreg[0];

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == ST_IDLE),
        .en   (state != ST_IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (tx_start) state_next = ST_START;
            ST_START:  if (tick) state_next = ST_DATA;
            ST_DATA:   if (tick && bit_cnt == LAST_DATA)
                           state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick) state_next = ST_STOP;
            ST_STOP:   if (tick && bit_cnt == LAST_STOP) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_next  = sel_of(state_next);
        busy_next = (state_next != ST_IDLE);
        done_next = (state == ST_STOP) && (state_next == ST_IDLE);
    end

    // Outputs are registered from the next-state values so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            selection <= SEL_STOP;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            selection <= sel_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    // bit_cnt indexes payload bits in DATA and stop bits in STOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
        end else if (accept) begin
            shreg      <= tx_data;
            parity_bit <= parity_calc;
            bit_cnt    <= '0;
        end else if (tick) begin
            if (state == ST_DATA) begin
                shreg   <= shreg >> 1;
                bit_cnt <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + BW'(1);
            end else if (state == ST_STOP) begin
                bit_cnt <= (bit_cnt == LAST_STOP) ? '0 : bit_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized bench for uart_tx_ctrl: three parameterisations checked against a frame-shape model.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
    localparam int DB  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       tx_start_v [3];
    logic [7:0] tx_data_v  [3];
    logic       busy_v [3], done_v [3], start_v [3], data_v [3], par_v [3], stop_v [3];
    logic [1:0] sel_v  [3];

    int checks   = 0;
    int failures = 0;

    // cfg 0: even parity, 1 stop; cfg 1: odd parity, 1 stop; cfg 2: no parity, 2 stops
    int pe_c    [3] = '{1, 1, 0};
    int odd_c   [3] = '{0, 1, 0};
    int stops_c [3] = '{1, 1, 2};

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_even (
        .clk(clk), .rst(rst), .tx_start(tx_start_v[0]), .tx_data(tx_data_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .selection(sel_v[0]), .start_bit(start_v[0]),
        .data_bit(data_v[0]), .parity_bit(par_v[0]), .stop_bit(stop_v[0]));

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_odd (
        .clk(clk), .rst(rst), .tx_start(tx_start_v[1]), .tx_data(tx_data_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .selection(sel_v[1]), .start_bit(start_v[1]),
        .data_bit(data_v[1]), .parity_bit(par_v[1]), .stop_bit(stop_v[1]));

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_nopar (
        .clk(clk), .rst(rst), .tx_start(tx_start_v[2]), .tx_data(tx_data_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .selection(sel_v[2]), .start_bit(start_v[2]),
        .data_bit(data_v[2]), .parity_bit(par_v[2]), .stop_bit(stop_v[2]));

    function automatic int frame_len(input int w);
        return CPB * (1 + DB + pe_c[w] + stops_c[w]);
    endfunction

    // Expected select for cycle c of a frame (c = 0 is the first start cycle).
    function automatic logic [1:0] exp_sel(input int w, input int c);
        int slot;
        slot = c / CPB;
        if (c >= frame_len(w)) return 2'b11;
        if (slot == 0) return 2'b00;
        if (slot <= DB) return 2'b01;
        if (pe_c[w] != 0 && slot == DB + 1) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic exp_data(input logic [7:0] d, input int c);
        return d[(c / CPB) - 1];
    endfunction

    function automatic logic exp_par(input int w, input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < DB; i++) ones += int'(d[i]);
        return ((ones % 2) == 1) ^ (odd_c[w] != 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int w = 0; w < 3; w++) begin
            tx_start_v[w] = 1'b0;
            tx_data_v[w]  = 8'h00;
        end
        repeat (3) step();
        for (int w = 0; w < 3; w++) begin
            logic [6:0] got;
            got = {sel_v[w], busy_v[w], done_v[w], data_v[w], par_v[w], start_v[w]};
            checks++;
            if (got !== 7'b1100000 || stop_v[w] !== 1'b1) begin
                failures++;
                $display("FAIL reset cfg%0d: {sel,busy,done,data,par,start}=%b stop=%b, want 1100000 stop=1",
                         w, got, stop_v[w]);
            end
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_framing();
        for (int w = 0; w < 3; w++) begin
            for (int n = 0; n < 6; n++) begin
                logic [7:0] d;
                int L, n_par, n_stop;
                d = 8'($urandom);
                if (w == 0 && n == 0) d = 8'hA5;
                if (w == 1 && n == 0) d = 8'h01;
                if (w == 1 && n == 1) d = 8'h00;
                if (w == 2 && n == 0) d = 8'hFF;
                L = frame_len(w);
                n_par = 0;
                n_stop = 0;
                tx_data_v[w]  = d;
                tx_start_v[w] = 1'b1;
                for (int c = 0; c <= L; c++) begin
                    step();
                    // Noise on the inputs while busy must not disturb the frame.
                    tx_start_v[w] = (c < L) ? 1'($urandom) : 1'b0;
                    tx_data_v[w]  = 8'($urandom);
                    if (c < L && sel_v[w] === 2'b10) n_par++;
                    if (c < L && sel_v[w] === 2'b11) n_stop++;
                    checks++;
                    if (sel_v[w] !== exp_sel(w, c) || busy_v[w] !== (c < L) || done_v[w] !== (c == L)) begin
                        failures++;
                        $display("FAIL frame cfg%0d d=%h c=%0d: sel=%b busy=%b done=%b, want sel=%b busy=%b done=%b",
                                 w, d, c, sel_v[w], busy_v[w], done_v[w], exp_sel(w, c), c < L, c == L);
                    end
                    if (c < L && exp_sel(w, c) == 2'b01) begin
                        checks++;
                        if (data_v[w] !== exp_data(d, c)) begin
                            failures++;
                            $display("FAIL data_bit cfg%0d d=%h c=%0d: got %b want %b",
                                     w, d, c, data_v[w], exp_data(d, c));
                        end
                    end
                    if (pe_c[w] != 0) begin
                        checks++;
                        if (par_v[w] !== exp_par(w, d)) begin
                            failures++;
                            $display("FAIL parity_bit cfg%0d d=%h c=%0d: got %b want %b",
                                     w, d, c, par_v[w], exp_par(w, d));
                        end
                    end
                end
                checks++;
                if (n_par != CPB * pe_c[w] || n_stop != CPB * stops_c[w]) begin
                    failures++;
                    $display("FAIL bit_counts cfg%0d d=%h: parity=%0d stop=%0d, want parity=%0d stop=%0d",
                             w, d, n_par, n_stop, CPB * pe_c[w], CPB * stops_c[w]);
                end
                repeat (2) step();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1, d2, d;
        int L, frames, idx;
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        L = frame_len(0);
        frames = 0;
        tx_data_v[0]  = d1;
        tx_start_v[0] = 1'b1;
        for (int c = 0; c <= 2 * L + 1; c++) begin
            step();
            if (done_v[0] === 1'b1) frames++;
            idx = (c <= L) ? c : c - L - 1;
            d   = (c <= L) ? d1 : d2;
            tx_data_v[0] = (c == L) ? d2 : 8'($urandom);
            if (c > L) tx_start_v[0] = (c < 2 * L + 1) ? 1'($urandom) : 1'b0;
            checks++;
            if (sel_v[0] !== exp_sel(0, idx) || done_v[0] !== (idx == L)) begin
                failures++;
                $display("FAIL b2b c=%0d: sel=%b done=%b, want sel=%b done=%b",
                         c, sel_v[0], done_v[0], exp_sel(0, idx), idx == L);
            end
            if (exp_sel(0, idx) == 2'b01) begin
                checks++;
                if (data_v[0] !== exp_data(d, idx)) begin
                    failures++;
                    $display("FAIL b2b data_bit c=%0d: got %b want %b", c, data_v[0], exp_data(d, idx));
                end
            end
        end
        repeat (10) begin
            step();
            if (done_v[0] === 1'b1) frames++;
        end
        checks++;
        if (frames != 2) begin
            failures++;
            $display("FAIL b2b frame_count: got %0d want 2", frames);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int L;
        L = frame_len(0);
        d = 8'($urandom);
        tx_data_v[0]  = d;
        tx_start_v[0] = 1'b1;
        for (int c = 0; c <= 4 + 3 * CPB + 1; c++) begin
            step();
            tx_start_v[0] = 1'b0;
        end
        checks++;
        if (sel_v[0] !== 2'b01 || busy_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_frame_pre: sel=%b busy=%b, want 01 1", sel_v[0], busy_v[0]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sel_v[0] !== 2'b11 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_frame_rst: sel=%b busy=%b done=%b, want 11 0 0", sel_v[0], busy_v[0], done_v[0]);
        end
        repeat (2) begin
            step();
            checks++;
            if (done_v[0] !== 1'b0 || sel_v[0] !== 2'b11) begin
                failures++;
                $display("FAIL rst_hold: sel=%b done=%b, want 11 0", sel_v[0], done_v[0]);
            end
        end
        rst = 1'b0;
        step();
        d = 8'($urandom);
        tx_data_v[0]  = d;
        tx_start_v[0] = 1'b1;
        for (int c = 0; c <= L; c++) begin
            step();
            tx_start_v[0] = 1'b0;
            checks++;
            if (sel_v[0] !== exp_sel(0, c) || done_v[0] !== (c == L)) begin
                failures++;
                $display("FAIL post_rst_frame c=%0d: sel=%b done=%b, want sel=%b done=%b",
                         c, sel_v[0], done_v[0], exp_sel(0, c), c == L);
            end
            if (exp_sel(0, c) == 2'b01) begin
                checks++;
                if (data_v[0] !== exp_data(d, c)) begin
                    failures++;
                    $display("FAIL post_rst data_bit c=%0d: got %b want %b", c, data_v[0], exp_data(d, c));
                end
            end
        end
    endtask

    task automatic test_idle();
        for (int w = 0; w < 3; w++) tx_start_v[w] = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step();
            for (int w = 0; w < 3; w++) begin
                tx_data_v[w] = 8'($urandom);
                checks++;
                if (sel_v[w] !== 2'b11 || busy_v[w] !== 1'b0 || done_v[w] !== 1'b0) begin
                    failures++;
                    $display("FAIL idle cfg%0d c=%0d: sel=%b busy=%b done=%b, want 11 0 0",
                             w, c, sel_v[w], busy_v[w], done_v[w]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_framing();
        test_back_to_back();
        test_reset_mid_frame();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
